// File: rtl/ctrl_barrier_bank_if.sv
// ctrl_barrier_bank_if: AXI-Stream style bundle for the barrier bank.
//   s_*  : per-channel argument input (producer -> bank)
//   m_*  : per-channel argument output (bank -> consumer)
// Channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH] (tdata) and
// [i*KEEP_WIDTH +: KEEP_WIDTH] (tkeep); the 1-bit signals are indexed by i.
// Modports: master = producer/consumer side, slave = the bank.
interface ctrl_barrier_bank_if #(
  parameter int PORT_COUNT = 10,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [PORT_COUNT*DATA_WIDTH-1:0] s_tdata;
  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_tkeep;
  logic [PORT_COUNT-1:0]            s_tlast;
  logic [PORT_COUNT-1:0]            s_tvalid;
  logic [PORT_COUNT-1:0]            s_tready;
  logic [PORT_COUNT*DATA_WIDTH-1:0] m_tdata;
  logic [PORT_COUNT*KEEP_WIDTH-1:0] m_tkeep;
  logic [PORT_COUNT-1:0]            m_tlast;
  logic [PORT_COUNT-1:0]            m_tvalid;
  logic [PORT_COUNT-1:0]            m_tready;

  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid,
    output m_tready
  );

  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid,
    input  m_tready
  );
endinterface

// File: rtl/ctrl_barrier_bank.sv
// ctrl_barrier_bank: PORT_COUNT argument channels, each buffered in a
// DEPTH-entry FIFO. MODE=0 releases one event at a time: the head of every
// channel is offered only once all channels hold data, and channels that have
// drained their argument stay gated until the slowest one finishes. MODE=1
// turns the bank into independent FIFOs.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   bus          : ctrl_barrier_bank_if.slave (s_* in, m_* out)
//   occupancy    : per-channel fill count, CNT_W bits per channel
//   event_count  : completed releases, wraps at 2^32
//   barrier_open : high while releasing (constant 1 in MODE=1)

// Per-channel FIFO; storage is plain registers, pointers wrap naturally
// because DEPTH is a power of two.
module ctrl_barrier_lane #(
  parameter int DW    = 8,
  parameter int KW    = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DW-1:0]    i_data,
  input  logic [KW-1:0]    i_keep,
  input  logic             i_last,
  output logic [DW-1:0]    o_data,
  output logic [KW-1:0]    o_keep,
  output logic             o_last,
  output logic [CNT_W-1:0] o_occ
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0][KW-1:0] r_keep;
  logic [DEPTH-1:0]         r_last;
  logic [AW-1:0]            r_wptr, r_rptr;
  logic [CNT_W-1:0]         r_occ;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_data[r_wptr] <= i_data;
      r_keep[r_wptr] <= i_keep;
      r_last[r_wptr] <= i_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data = r_data[r_rptr];
  assign o_keep = r_keep[r_rptr];
  assign o_last = r_last[r_rptr];
  assign o_occ  = r_occ;
endmodule

module ctrl_barrier_bank #(
  parameter int                    PORT_COUNT  = 10,
  parameter int                    DATA_WIDTH  = 512,
  parameter int                    KEEP_WIDTH  = DATA_WIDTH/8,
  parameter int                    DEPTH       = 4,
  parameter logic [PORT_COUNT-1:0] STREAM_MASK = '0,
  parameter int                    MODE        = 0,
  parameter int                    CNT_W       = $clog2(DEPTH+1)
)(
  input  logic                        clk,
  input  logic                        rst,
  ctrl_barrier_bank_if.slave          bus,
  output logic [PORT_COUNT*CNT_W-1:0] occupancy,
  output logic [31:0]                 event_count,
  output logic                        barrier_open
);
  typedef enum logic [0:0] {S_WAIT_ALL, S_RELEASE} state_t;

  logic [PORT_COUNT-1:0]                 w_push, w_pop, w_bpop;
  logic [PORT_COUNT-1:0]                 w_nonempty, w_full, w_last, w_mvalid;
  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] w_data;
  logic [PORT_COUNT-1:0][KEEP_WIDTH-1:0] w_keep;
  logic [PORT_COUNT-1:0][CNT_W-1:0]      w_occ;

  state_t                r_state, w_state_nxt;
  logic [PORT_COUNT-1:0] r_done, w_done_nxt;
  logic                  w_ev_inc;
  logic [31:0]           r_event_count;
  // Holds s_tready low through reset and for the first edge after release.
  logic                  r_live;

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_lane
    ctrl_barrier_lane #(
      .DW(DATA_WIDTH), .KW(KEEP_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push[g]),
      .i_pop  (w_pop[g]),
      .i_data (bus.s_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_keep (bus.s_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH]),
      .i_last (bus.s_tlast[g]),
      .o_data (w_data[g]),
      .o_keep (w_keep[g]),
      .o_last (w_last[g]),
      .o_occ  (w_occ[g])
    );
    assign w_nonempty[g] = (w_occ[g] != '0);
    assign w_full[g]     = (w_occ[g] == CNT_W'(DEPTH));
    assign w_push[g]     = bus.s_tvalid[g] & r_live & ~w_full[g];
    assign w_pop[g]      = w_mvalid[g] & bus.m_tready[g];
    // Non-stream channels end their argument on every beat; tlast is ignored.
    assign w_bpop[g]     = w_pop[g] & (STREAM_MASK[g] ? w_last[g] : 1'b1);
  end

  // Output valid: only registered state, done and occupancy feed this.
  always_comb begin
    w_mvalid = '0;
    if (MODE == 1)                   w_mvalid = w_nonempty;
    else if (r_state == S_RELEASE)   w_mvalid = ~r_done & w_nonempty;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_ev_inc    = 1'b0;
    if (MODE == 1) begin
      w_ev_inc = w_bpop[0];
    end else begin
      case (r_state)
        S_WAIT_ALL: if (&w_nonempty) w_state_nxt = S_RELEASE;
        S_RELEASE: begin
          // Close the barrier on the edge the last argument boundary drains.
          if (&(r_done | w_bpop)) begin
            w_state_nxt = S_WAIT_ALL;
            w_done_nxt  = '0;
            w_ev_inc    = 1'b1;
          end else begin
            w_done_nxt  = r_done | w_bpop;
          end
        end
        default: w_state_nxt = S_WAIT_ALL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_WAIT_ALL;
      r_done        <= '0;
      r_event_count <= '0;
      r_live        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_nxt;
      r_event_count <= r_event_count + 32'(w_ev_inc);
      r_live        <= 1'b1;
    end
  end

  assign bus.s_tready = r_live ? ~w_full : '0;
  assign bus.m_tvalid = w_mvalid;
  assign bus.m_tdata  = w_data;
  assign bus.m_tkeep  = w_keep;
  assign bus.m_tlast  = w_last;
  assign occupancy    = w_occ;
  assign event_count  = r_event_count;
  assign barrier_open = (MODE == 1) ? 1'b1 : (r_state == S_RELEASE);
endmodule

// File: tb/tb_ctrl_barrier_bank.sv
// Directed bench: lockstep bank (10 x 512b, DEPTH 4, channel 8 streaming)
// plus a small bypass-mode bank sharing clock and reset.
module tb_ctrl_barrier_bank;
  localparam int PC = 10, DW = 512, KW = 64, CW = 3;
  localparam logic [PC-1:0] ALL = '1;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  logic [PC-1:0][DW-1:0] s_data;
  logic [PC-1:0][KW-1:0] s_keep;
  logic [PC-1:0]         s_last, s_valid, m_ready;
  logic [PC*CW-1:0]      occ;
  logic [31:0]           evc;
  logic                  bopen;
  logic [3:0][KW-1:0]    kk;

  ctrl_barrier_bank_if #(.PORT_COUNT(PC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus();
  assign bus.s_tdata  = s_data;
  assign bus.s_tkeep  = s_keep;
  assign bus.s_tlast  = s_last;
  assign bus.s_tvalid = s_valid;
  assign bus.m_tready = m_ready;

  ctrl_barrier_bank #(
    .PORT_COUNT(PC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(4),
    .STREAM_MASK(10'h100), .MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .occupancy(occ), .event_count(evc), .barrier_open(bopen)
  );

  // Bypass-mode instance: 2 channels x 8b, channel 0 streaming.
  logic [1:0][7:0] s1_data;
  logic [1:0]      s1_keep, s1_last, s1_valid, m1_ready;
  logic [5:0]      occ1;
  logic [31:0]     evc1;
  logic            bopen1;

  ctrl_barrier_bank_if #(.PORT_COUNT(2), .DATA_WIDTH(8), .KEEP_WIDTH(1)) bus1();
  assign bus1.s_tdata  = s1_data;
  assign bus1.s_tkeep  = s1_keep;
  assign bus1.s_tlast  = s1_last;
  assign bus1.s_tvalid = s1_valid;
  assign bus1.m_tready = m1_ready;

  ctrl_barrier_bank #(
    .PORT_COUNT(2), .DATA_WIDTH(8), .KEEP_WIDTH(1), .DEPTH(4),
    .STREAM_MASK(2'b01), .MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .occupancy(occ1), .event_count(evc1), .barrier_open(bopen1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int c, input int e, input int b);
    return DW'({8'hA5, 8'(c), 8'(e), 8'(b)});
  endfunction

  function automatic logic [DW-1:0] mdata(input int c);
    return bus.m_tdata[c*DW +: DW];
  endfunction

  // One-edge push on the channels in mask; data tagged (channel, event, beat).
  task automatic push(input logic [PC-1:0] mask, input int e, input int b,
                      input logic [PC-1:0] lastm, input logic [KW-1:0] keep);
    for (int c = 0; c < PC; c++) begin
      s_data[c] = pat(c, e, b);
      s_keep[c] = keep;
    end
    s_last  = lastm;
    s_valid = mask;
    @(negedge clk);
    s_valid = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_data = '0; s_keep = '0; s_last = '0; s_valid = '0; m_ready = '0;
    s1_data = '0; s1_keep = '1; s1_last = '0; s1_valid = '0; m1_ready = '0;
    kk[0] = 64'h1; kk[1] = 64'h3; kk[2] = 64'hF; kk[3] = '1;

    // Reset with random input activity
    repeat (3) begin
      s_valid  = PC'($urandom);
      s1_valid = 2'($urandom);
      @(negedge clk);
    end
    chk("rst_mvalid",  bus.m_tvalid, '0);
    chk("rst_sready",  bus.s_tready, '0);
    chk("rst_evc",     evc, '0);
    chk("rst_occ",     occ, '0);
    chk("rst_open",    bopen, '0);
    chk("rst_mvalid1", bus1.m_tvalid, '0);
    s_valid = '0; s1_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_sready",  bus.s_tready, ALL);
    chk("rel_open1",   bopen1, 1'b1);

    // Skewed arrival: channel 9 arrives 5 edges after the rest
    m_ready = ALL;
    push(10'h1FF, 1, 0, ALL, '1);
    for (int t = 0; t < 4; t++) begin
      chk("skew_idle", bus.m_tvalid, '0);
      @(negedge clk);
    end
    push(10'h200, 1, 0, ALL, '1);
    chk("skew_wait",  bus.m_tvalid, '0);
    @(negedge clk);
    chk("skew_rel",   bus.m_tvalid, ALL);
    chk("skew_open",  bopen, 1'b1);
    chk("skew_d5",    mdata(5), pat(5, 1, 0));
    chk("skew_d9",    mdata(9), pat(9, 1, 0));
    @(negedge clk);
    chk("skew_evc",   evc, 32'd1);
    chk("skew_done",  bus.m_tvalid, '0);
    chk("skew_occ",   occ, '0);

    // Partial drain: channel 3 stalls with a second event queued everywhere
    m_ready = ALL & ~10'h008;
    push(ALL, 2, 0, ALL, '1);
    push(ALL, 3, 0, ALL, '1);
    chk("pd_rel1", bus.m_tvalid, ALL);
    @(negedge clk);
    chk("pd_occ0", occ[2:0], 3'd1);
    for (int t = 0; t < 4; t++) begin
      chk("pd_hold", bus.m_tvalid, 10'h008);
      @(negedge clk);
    end
    chk("pd_evc_hold", evc, 32'd1);
    m_ready = ALL;
    @(negedge clk);
    chk("pd_gap",  bus.m_tvalid, '0);
    chk("pd_evc2", evc, 32'd2);
    @(negedge clk);
    chk("pd_rel2", bus.m_tvalid, ALL);
    chk("pd_d3",   mdata(3), pat(3, 3, 0));
    @(negedge clk);
    chk("pd_evc3", evc, 32'd3);

    // Stream channel 8: 4-beat packet, tlast on beat 4
    m_ready = '0;
    push(ALL, 4, 0, ALL & ~10'h100, kk[0]);
    push(10'h100, 4, 1, '0, kk[1]);
    push(10'h100, 4, 2, '0, kk[2]);
    push(10'h100, 4, 3, 10'h100, kk[3]);
    chk("st_occ8", occ[8*CW +: CW], 3'd4);
    m_ready = ALL;
    for (int b = 0; b < 4; b++) begin
      chk("st_vld",  bus.m_tvalid, (b == 0) ? ALL : 10'h100);
      chk("st_data", mdata(8), pat(8, 4, b));
      chk("st_keep", bus.m_tkeep[8*KW +: KW], kk[b]);
      chk("st_evc",  evc, 32'd3);
      @(negedge clk);
    end
    chk("st_evc_end", evc, 32'd4);
    chk("st_idle",    bus.m_tvalid, '0);

    // Full FIFO on channel 0, dropped 5th push, then ordered drain + re-push
    m_ready = '0;
    for (int k = 0; k < 4; k++) push(10'h001, 5, k, ALL, '1);
    chk("ff_occ0",   occ[2:0], 3'd4);
    chk("ff_sready", bus.s_tready, 10'h3FE);
    push(10'h001, 9, 9, ALL, '1);
    chk("ff_occ0_drop", occ[2:0], 3'd4);
    for (int k = 0; k < 4; k++) push(10'h3FE, 5, k, ALL, '1);
    m_ready = ALL;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 4 && bus.m_tvalid !== ALL; t++) @(negedge clk);
      chk("ff_vld",   bus.m_tvalid, ALL);
      chk("ff_order", mdata(0), pat(0, 5, k));
      @(negedge clk);
      if (k == 0) push(ALL, 5, 4, ALL, '1);
    end
    chk("ff_evc", evc, 32'd9);
    chk("ff_occ", occ, '0);

    // Reset in the middle of a release
    m_ready = 10'h003;
    push(ALL, 7, 0, ALL, '1);
    push(ALL, 7, 1, ALL, '1);
    chk("mr_rel",  bus.m_tvalid, ALL);
    @(negedge clk);
    chk("mr_part", bus.m_tvalid, 10'h3FC);
    rst = 1'b0;
    #1;
    chk("mr_occ",    occ, '0);
    chk("mr_mvalid", bus.m_tvalid, '0);
    chk("mr_evc",    evc, '0);
    chk("mr_open",   bopen, 1'b0);
    chk("mr_sready", bus.s_tready, '0);
    @(negedge clk);
    rst = 1'b1;
    m_ready = ALL;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("mr_nostale", bus.m_tvalid, '0);
    end
    chk("mr_occ_post", occ, '0);
    push(ALL, 8, 0, ALL, '1);
    @(negedge clk);
    chk("mr_new_vld", bus.m_tvalid, ALL);
    chk("mr_new_d4",  mdata(4), pat(4, 8, 0));
    @(negedge clk);
    chk("mr_new_evc", evc, 32'd1);

    // Bypass mode: independent FIFOs, event counted on channel-0 tlast
    m1_ready = '0;
    s1_data[0] = 8'h11; s1_last = 2'b00; s1_valid = 2'b01;
    @(negedge clk);
    s1_valid = '0;
    chk("m1_lat",  bus1.m_tvalid, 2'b01);
    chk("m1_open", bopen1, 1'b1);
    s1_data[0] = 8'h22; s1_data[1] = 8'h33; s1_last = 2'b01; s1_valid = 2'b11;
    @(negedge clk);
    s1_valid = '0;
    chk("m1_vld2", bus1.m_tvalid, 2'b11);
    chk("m1_occ0", occ1[2:0], 3'd2);
    m1_ready = 2'b11;
    @(negedge clk);
    chk("m1_evc0", evc1, '0);
    chk("m1_vld3", bus1.m_tvalid, 2'b01);
    chk("m1_d0",   bus1.m_tdata[7:0], 8'h22);
    @(negedge clk);
    chk("m1_evc1", evc1, 32'd1);
    chk("m1_idle", bus1.m_tvalid, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
